// File: rtl/mem_access.sv
// Memory-access stage for the dual-issue core: drives one BRAM port per slot,
// resolves same-bundle address conflicts and aligns bundle info with read data.
module mem_access #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              interlock,
  input  logic [31:0]       pc_from_exec,
  input  logic [63:0]       inst_from_exec,
  input  logic [31:0]       u_addr_from_exec,
  input  logic [31:0]       l_addr_from_exec,
  input  logic [31:0]       u_sdata_from_exec,
  input  logic [31:0]       l_sdata_from_exec,
  input  logic [4:0]        u_rt_from_exec,
  input  logic [4:0]        l_rt_from_exec,
  output logic              mem_ena,
  output logic              mem_enb,
  output logic              mem_wea,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [ADDR_W-1:0] mem_addrb,
  output logic [31:0]       mem_dina,
  output logic [31:0]       mem_dinb,
  input  logic [31:0]       mem_douta,
  input  logic [31:0]       mem_doutb_raw,
  output logic [31:0]       pc_to_wb,
  output logic [63:0]       inst_to_wb,
  output logic [4:0]        u_rt_to_wb,
  output logic [4:0]        l_rt_to_wb,
  output logic [63:0]       mem_doutb
);

  localparam logic [5:0] OP_LOAD  = 6'h23;
  localparam logic [5:0] OP_STORE = 6'h2B;

  logic u_ld, u_st, l_ld, l_st;
  logic same_addr, req_ok, fwd_cond;

  logic [31:0] pc_p1;
  logic [63:0] inst_p1;
  logic [4:0]  u_rt_p1, l_rt_p1;
  logic        fwd_l_p1;
  logic [31:0] fwd_data_p1;

  // High address bits are outside the BRAM; intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{u_addr_from_exec[31:ADDR_W], l_addr_from_exec[31:ADDR_W]};

  assign u_ld = (inst_from_exec[63:58] == OP_LOAD);
  assign u_st = (inst_from_exec[63:58] == OP_STORE);
  assign l_ld = (inst_from_exec[31:26] == OP_LOAD);
  assign l_st = (inst_from_exec[31:26] == OP_STORE);

  assign same_addr = (u_addr_from_exec[ADDR_W-1:0] == l_addr_from_exec[ADDR_W-1:0]);
  // Requests are also gated by rstn so nothing is written while reset is held.
  assign req_ok    = rstn & ~interlock;
  assign fwd_cond  = u_st & l_ld & same_addr;

  // Stage 0: combinational request generation
  assign mem_ena   = req_ok & (u_ld | u_st);
  // Lower store is later in program order, so it wins a same-address store pair.
  assign mem_wea   = req_ok & u_st & ~(l_st & same_addr);
  assign mem_enb   = req_ok & (l_ld | l_st);
  assign mem_web   = req_ok & l_st;
  assign mem_addra = u_addr_from_exec[ADDR_W-1:0];
  assign mem_addrb = l_addr_from_exec[ADDR_W-1:0];
  assign mem_dina  = u_sdata_from_exec;
  assign mem_dinb  = l_sdata_from_exec;

  // Stage 1: bundle registers aligned with BRAM read latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_p1       <= '0;
      inst_p1     <= '0;
      u_rt_p1     <= '0;
      l_rt_p1     <= '0;
      fwd_l_p1    <= 1'b0;
      fwd_data_p1 <= '0;
    end else if (!interlock) begin
      pc_p1       <= pc_from_exec;
      inst_p1     <= inst_from_exec;
      u_rt_p1     <= u_rt_from_exec;
      l_rt_p1     <= l_rt_from_exec;
      fwd_l_p1    <= fwd_cond;
      fwd_data_p1 <= u_sdata_from_exec;
    end
  end

  assign pc_to_wb   = pc_p1;
  assign inst_to_wb = inst_p1;
  assign u_rt_to_wb = u_rt_p1;
  assign l_rt_to_wb = l_rt_p1;
  assign mem_doutb  = {mem_douta, (fwd_l_p1 ? fwd_data_p1 : mem_doutb_raw)};

endmodule
